// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: the requester drives start and operands,
// the ALU returns busy/done/illegal, the registered result and the PSR flags.
interface alu_seq_if #(
    parameter int WIDTH   = 16,
    parameter int CTL_LEN = 8
);
    logic               start;
    logic [CTL_LEN-1:0] operationControl;
    logic [WIDTH-1:0]   sourceData;
    logic [WIDTH-1:0]   destData;
    logic               busy;
    logic               done;
    logic               illegal;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               low;
    logic               overflow;
    logic               zero;
    logic               negative;

    modport master (
        output start, operationControl, sourceData, destData,
        input  busy, done, illegal, result, carry, low, overflow, zero, negative
    );

    modport slave (
        input  start, operationControl, sourceData, destData,
        output busy, done, illegal, result, carry, low, overflow, zero, negative
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ALU ops run in EXEC, MUL runs as a WIDTH-cycle
// shift-add in its own state; result and PSR flags are registered on completion.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int CTL_LEN = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_ADDU  = 4'b0110;
    localparam logic [3:0] OP_ADDC  = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_SUBC  = 4'b1010;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_MOV   = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;
    localparam logic [7:0] MUL_CTL  = 8'h0E;

    localparam logic [3:0] SH_LSHI_L  = 4'b0000;
    localparam logic [3:0] SH_LSHI_R  = 4'b0001;
    localparam logic [3:0] SH_ASHUI_L = 4'b0010;
    localparam logic [3:0] SH_ASHUI_R = 4'b0011;
    localparam logic [3:0] SH_LSH     = 4'b0100;
    localparam logic [3:0] SH_ASHU    = 4'b0110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t             state_q, state_d;
    logic [CTL_LEN-1:0] ctl_q, ctl_d;
    logic [WIDTH-1:0]   src_q, src_d;
    logic [WIDTH-1:0]   dst_q, dst_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               low_q, low_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               negative_q, negative_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;

    logic               is_r;
    logic [3:0]         fn;
    logic               cin;
    logic [WIDTH:0]     uadd, sadd, usub, ssub;
    logic [WIDTH:0]     amt_pos, amt_neg, amt_imm;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_legal;
    logic               f_carry, f_low, f_ovf, f_zero, f_neg;

    function automatic logic [WIDTH-1:0] sh_left(input logic [WIDTH-1:0] v, input logic [WIDTH:0] amt);
        if (amt >= (WIDTH+1)'(WIDTH)) return '0;
        else return v << amt;
    endfunction

    function automatic logic [WIDTH-1:0] sh_right(input logic [WIDTH-1:0] v, input logic [WIDTH:0] amt);
        if (amt >= (WIDTH+1)'(WIDTH)) return '0;
        else return v >> amt;
    endfunction

    function automatic logic [WIDTH-1:0] sh_arith(input logic [WIDTH-1:0] v, input logic [WIDTH:0] amt);
        if (amt >= (WIDTH+1)'(WIDTH)) return {WIDTH{v[WIDTH-1]}};
        else return $signed(v) >>> amt;
    endfunction

    // R-type ops carry the function in the sub-op, I-type ops in the opcode.
    always_comb begin
        is_r      = (ctl_q[7:4] == OP_RTYPE);
        fn        = is_r ? ctl_q[3:0] : ctl_q[7:4];
        cin       = is_r && (fn == OP_ADDC || fn == OP_SUBC) && carry_q;
        uadd      = {1'b0, dst_q} + {1'b0, src_q} + {{WIDTH{1'b0}}, cin};
        sadd      = {dst_q[MSB], dst_q} + {src_q[MSB], src_q} + {{WIDTH{1'b0}}, cin};
        usub      = {1'b0, dst_q} - {1'b0, src_q} - {{WIDTH{1'b0}}, cin};
        ssub      = {dst_q[MSB], dst_q} - {src_q[MSB], src_q} - {{WIDTH{1'b0}}, cin};
        amt_pos   = {1'b0, src_q};
        amt_neg   = {1'b0, ~src_q} + {{WIDTH{1'b0}}, 1'b1};
        amt_imm   = {{(WIDTH+1-SHW){1'b0}}, src_q[SHW-1:0]};
        alu_res   = '0;
        alu_legal = 1'b1;
        f_carry   = carry_q;
        f_low     = low_q;
        f_ovf     = overflow_q;
        f_zero    = zero_q;
        f_neg     = negative_q;
        case (fn)
            OP_AND: alu_res = dst_q & src_q;
            OP_OR:  alu_res = dst_q | src_q;
            OP_XOR: alu_res = dst_q ^ src_q;
            OP_MOV: alu_res = src_q;
            OP_LUI: begin
                alu_legal = !is_r;
                if (alu_legal) alu_res = src_q << 8;
            end
            OP_ADD, OP_ADDU, OP_ADDC: begin
                alu_legal = is_r || fn != OP_ADDC;
                if (alu_legal) begin
                    alu_res = uadd[MSB:0];
                    f_carry = uadd[WIDTH];
                    f_ovf   = sadd[WIDTH] ^ sadd[MSB];
                    f_neg   = uadd[MSB] ^ (sadd[WIDTH] ^ sadd[MSB]);
                    f_zero  = (uadd[MSB:0] == '0);
                    f_low   = 1'b0;
                end
            end
            OP_SUB, OP_SUBC: begin
                alu_legal = is_r || fn != OP_SUBC;
                if (alu_legal) begin
                    alu_res = usub[MSB:0];
                    f_carry = usub[WIDTH];
                    f_ovf   = ssub[WIDTH] ^ ssub[MSB];
                    f_neg   = usub[MSB] ^ (ssub[WIDTH] ^ ssub[MSB]);
                    f_zero  = (usub[MSB:0] == '0);
                    f_low   = usub[WIDTH];
                end
            end
            OP_CMP: begin
                f_carry = 1'b0;
                f_ovf   = 1'b0;
                f_low   = (src_q > dst_q);
                f_neg   = ($signed(dst_q) < $signed(src_q));
                f_zero  = (dst_q == src_q);
            end
            OP_SHIFT: begin
                alu_legal = !is_r;
                if (alu_legal) begin
                    case (ctl_q[3:0])
                        SH_LSHI_L:  alu_res = sh_left(dst_q, (WIDTH+1)'(1));
                        SH_LSHI_R:  alu_res = sh_right(dst_q, (WIDTH+1)'(1));
                        SH_ASHUI_L: alu_res = sh_left(dst_q, amt_imm);
                        SH_ASHUI_R: alu_res = sh_arith(dst_q, amt_imm);
                        SH_LSH:     alu_res = src_q[MSB] ? sh_right(dst_q, amt_neg) : sh_left(dst_q, amt_pos);
                        SH_ASHU:    alu_res = src_q[MSB] ? sh_arith(dst_q, amt_neg) : sh_left(dst_q, amt_pos);
                        default:    alu_legal = 1'b0;
                    endcase
                end
            end
            default: alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ctl_d      = ctl_q;
        src_d      = src_q;
        dst_d      = dst_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        carry_d    = carry_q;
        low_d      = low_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ctl_d   = bus.operationControl;
                    src_d   = bus.sourceData;
                    dst_d   = bus.destData;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (bus.operationControl[7:0] == MUL_CTL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                result_d   = alu_res;
                carry_d    = f_carry;
                low_d      = f_low;
                overflow_d = f_ovf;
                zero_d     = f_zero;
                negative_d = f_neg;
                illegal_d  = !alu_legal;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            MUL: begin
                // Operand registers double as the shifting multiplicand/multiplier.
                acc_d = acc_q + (src_q[0] ? dst_q : '0);
                src_d = src_q >> 1;
                dst_d = dst_q << 1;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_d;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctl_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            low_q      <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctl_q      <= ctl_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            low_q      <= low_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.low      = low_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
    assign bus.negative = negative_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: issued ops push expected responses computed by a
// plain-arithmetic reference model; a negedge monitor pops and compares on done.
module tb_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .CTL_LEN(8)) bus ();
    alu_seq #(.WIDTH(W), .CTL_LEN(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   flg;   // {carry, low, overflow, zero, negative}
        bit           ill;
        int           due;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    logic [4:0] mflg = '0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    logic [7:0] op_tbl [0:22] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A,
                                  8'h0B, 8'h0D, 8'h0E, 8'h10, 8'h20, 8'h30, 8'h50, 8'h60,
                                  8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h80, 8'h84, 8'h86};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] shl(input longint v, input longint n);
        if (n >= W) return '0;
        return W'(v * (longint'(1) << n));
    endfunction

    function automatic logic [W-1:0] shr(input longint v, input longint n);
        if (n >= W) return '0;
        return W'(v / (longint'(1) << n));
    endfunction

    // floor(v / 2^n) on a signed value; huge amounts saturate to 0 or -1
    function automatic logic [W-1:0] sar(input longint v, input longint n);
        longint nn;
        nn = (n > 40) ? 40 : n;
        return W'(v >>> nn);
    endfunction

    task automatic model(input logic [7:0] ctl, input logic [W-1:0] s, input logic [W-1:0] d,
                         output exp_t e, output int lat);
        longint us, ud, ss, sd, t, st, lim;
        logic [3:0] op, sub, f;
        bit cin, ovf;
        us  = longint'(s);
        ud  = longint'(d);
        ss  = longint'($signed(s));
        sd  = longint'($signed(d));
        lim = longint'(1) << (W - 1);
        op  = ctl[7:4];
        sub = ctl[3:0];
        f   = (op == 4'h0) ? sub : op;
        e.res = '0;
        e.flg = mflg;
        e.ill = 1'b0;
        e.due = 0;
        lat   = 1;
        if ((op == 4'h0 && sub inside {4'h5, 4'h6, 4'h7}) || op inside {4'h5, 4'h6}) begin
            cin = (op == 4'h0 && sub == 4'h7) ? mflg[4] : 1'b0;
            t   = ud + us + cin;
            st  = sd + ss + cin;
            ovf = (st >= lim) || (st < -lim);
            e.res = W'(t);
            e.flg = {t >= 2 * lim, 1'b0, ovf, e.res == '0, e.res[W-1] ^ ovf};
        end else if ((op == 4'h0 && sub inside {4'h9, 4'hA}) || op == 4'h9) begin
            cin = (op == 4'h0 && sub == 4'hA) ? mflg[4] : 1'b0;
            t   = ud - us - cin;
            st  = sd - ss - cin;
            ovf = (st >= lim) || (st < -lim);
            e.res = W'(t);
            e.flg = {t < 0, t < 0, ovf, e.res == '0, e.res[W-1] ^ ovf};
        end else if (f == 4'hB && !(op == 4'h0 && sub == 4'h0)) begin
            e.flg = {1'b0, us > ud, 1'b0, ud == us, sd < ss};
        end else if (f inside {4'h1, 4'h2, 4'h3, 4'hD}) begin
            case (f)
                4'h1:    e.res = d & s;
                4'h2:    e.res = d | s;
                4'h3:    e.res = d ^ s;
                default: e.res = s;
            endcase
        end else if (op == 4'hF) begin
            e.res = W'(us * 256);
        end else if (op == 4'h0 && sub == 4'hE) begin
            e.res = W'(ud * us);
            lat   = W;
        end else if (op == 4'h8 && sub inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6}) begin
            case (sub)
                4'h0:    e.res = shl(ud, 1);
                4'h1:    e.res = shr(ud, 1);
                4'h2:    e.res = shl(ud, us % W);
                4'h3:    e.res = sar(sd, us % W);
                4'h4:    e.res = (ss >= 0) ? shl(ud, ss) : shr(ud, -ss);
                default: e.res = (ss >= 0) ? shl(ud, ss) : sar(sd, -ss);
            endcase
        end else begin
            e.ill = 1'b1;
        end
        mflg = e.flg;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one request; junk inputs and ignored start pulses while it is in flight.
    task automatic issue(input logic [7:0] ctl, input logic [W-1:0] s, input logic [W-1:0] d);
        exp_t e;
        int lat;
        bus.start = 1'b1;
        bus.operationControl = ctl;
        bus.sourceData = s;
        bus.destData = d;
        @(posedge clk);
        #1;
        model(ctl, s, d, e, lat);
        e.due = cyc + lat;
        sbq.push_back(e);
        for (int i = 0; i < lat; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.operationControl = 8'($urandom);
            bus.sourceData = W'($urandom);
            bus.destData = W'($urandom);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return W'(16'h8000);
            3: return W'(16'h7FFF);
            4: return W'(int'($urandom_range(0, 40)) - 20);
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("illegal_without_done", {31'b0, bus.illegal & ~bus.done}, 32'd0);
            check("busy", {31'b0, bus.busy}, {31'b0, sbq.size() > 0 && cyc < sbq[0].due});
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", {16'b0, bus.result}, {16'b0, mon_e.res});
                    check("flags", {27'b0, bus.carry, bus.low, bus.overflow, bus.zero, bus.negative},
                          {27'b0, mon_e.flg});
                    check("illegal", {31'b0, bus.illegal}, {31'b0, mon_e.ill});
                    check("latency", cyc, mon_e.due);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_timeout: got no done, expected done at cycle %0d", sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion before 1 ms");
        $fatal(1);
    end

    initial begin
        logic [7:0] ctl;
        bus.start = 1'b0;
        bus.operationControl = '0;
        bus.sourceData = '0;
        bus.destData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_status", {29'b0, bus.busy, bus.done, bus.illegal}, 32'd0);
        check("reset_result", {16'b0, bus.result}, 32'd0);
        check("reset_flags", {27'b0, bus.carry, bus.low, bus.overflow, bus.zero, bus.negative}, 32'd0);
        reset = 1'b0;
        idle(5);

        issue(8'h05, 16'h0001, 16'h7FFF);
        issue(8'h05, 16'h0001, 16'hFFFF);
        issue(8'h07, 16'h0000, 16'h0000);
        idle(2);
        issue(8'h0E, 16'h0045, 16'h0123);
        issue(8'h0B, 16'h0005, 16'h0003);
        issue(8'h0B, 16'h1234, 16'h1234);
        issue(8'h70, 16'h1111, 16'h2222);
        issue(8'h84, 16'hFFFC, 16'h8001);
        issue(8'h86, 16'hFFFC, 16'h8001);
        issue(8'h86, 16'hFFE0, 16'h8001);
        issue(8'h84, 16'h0010, 16'hFFFF);
        idle(1);

        // Abort a MUL in its eighth cycle: outputs clear at once, no done follows.
        bus.start = 1'b1;
        bus.operationControl = 8'h0E;
        bus.sourceData = 16'h0045;
        bus.destData = 16'h0123;
        @(posedge clk);
        #1;
        sbq.push_back('{res: '0, flg: mflg, ill: 1'b0, due: cyc + W});
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_status", {29'b0, bus.busy, bus.done, bus.illegal}, 32'd0);
        check("abort_result", {16'b0, bus.result}, 32'd0);
        sbq.delete();
        mflg = '0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        idle(20);
        issue(8'h05, 16'h0002, 16'h0003);
        issue(8'h07, 16'h0000, 16'h0000);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                ctl = 8'($urandom);
            end else begin
                ctl = op_tbl[$urandom_range(0, 22)];
                if (ctl[7:4] != 4'h0 && ctl[7:4] != 4'h8) ctl[3:0] = 4'($urandom);
                if (ctl == 8'h80 || ctl == 8'h84) ctl[1:0] = 2'($urandom);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            issue(ctl, pick_operand(), pick_operand());
        end

        idle(3);
        for (int i = 0; i < 40 && sbq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter CTL_LEN, default 8, width of operationControl; opcode is operationControl[7:4], sub-op is [3:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 operationControl  input  CTL_LEN  operation select, same encoding as the existing combinational ALU.
REQ-007 sourceData, destData  input  WIDTH each  operands (src, dst).
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse; result/flags valid from that cycle on.
REQ-010 illegal  output  1  high with done when the opcode/sub-op is undefined.
REQ-011 result  output  WIDTH  registered result, held until the next done.
REQ-012 carry, low, overflow, zero, negative  output  1 each  registered flag register (PSR).

Function
REQ-013 SHALL have states IDLE, EXEC, MUL; IDLE+start+MUL (RTYPE 1110) -> MUL; IDLE+start+other op -> EXEC; EXEC -> IDLE after 1 cycle; MUL -> IDLE after WIDTH cycles.
REQ-014 SHALL latch operationControl, sourceData, destData on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-015 SHALL ignore start while busy (no queueing); start in the cycle done is high SHALL be accepted (back-to-back).
REQ-016 Latency: start at edge k -> result/flags/done registered at edge k+1 (single-cycle ops) or edge k+WIDTH (MUL).
REQ-017 busy SHALL be high exactly in EXEC and MUL; done SHALL be high exactly one cycle per accepted operation.
REQ-018 Add ops (ADD, ADDU, ADDI, ADDUI): result = dst+src mod 2^WIDTH; carry = bit WIDTH of the sum.
REQ-019 ADDC: result = dst+src+stored carry flag; carry = carry-out.
REQ-020 Sub ops (SUB, SUBI): result = dst-src; SUBC: result = dst-src-stored carry; carry = borrow (unsigned dst < src + carry-in).
REQ-021 Add/sub flags: overflow = signed overflow; negative = result MSB XOR overflow (true signed sign); zero = (result == 0); low = 0 for add, borrow for sub.
REQ-022 CMP/CMPI: result = 0; low = unsigned src > dst; negative = signed dst < src; zero = (dst == src); carry = overflow = 0.
REQ-023 AND/OR/XOR (R and I forms), MOV/MOVI, LUI (src << 8), shifts, MUL SHALL write result and leave all flags unchanged.
REQ-024 Shifts (opcode 1000): LSH/ASHU use signed src as the amount (positive = left, negative = right; ASHU right is arithmetic); LSHI+/LSHI- shift by 1; ASHUI+/ASHUI- shift by src[low bits]; |amount| >= WIDTH SHALL give 0 (all-sign for arithmetic right).
REQ-025 MUL: unsigned iterative shift-add, one multiplier bit per cycle; result = low WIDTH bits of product.
REQ-026 Undefined op: result = 0, flags unchanged, illegal = 1 with done, normal EXEC latency.
REQ-027 illegal SHALL be 0 in every cycle in which done is 0.

Reset
REQ-028 reset SHALL immediately force state IDLE; busy, done, illegal, result, and all flags SHALL be 0.
REQ-029 reset mid-operation SHALL abort it; no done pulse SHALL follow for the aborted operation.
REQ-030 After reset deassertion, the first start SHALL be accepted normally; a reset-cleared carry = 0 feeds ADDC/SUBC.

Verification (WIDTH=16)
REQ-031 Assert reset -> all outputs 0; release, idle 5 cycles -> busy/done stay 0.
REQ-032 ADD src=0x0001, dst=0x7FFF -> next edge: result 0x8000, overflow 1, negative 0, carry 0, zero 0, done 1 cycle.
REQ-033 ADD 0xFFFF+0x0001, then back-to-back ADDC 0x0000+0x0000 -> result 0x0000, carry 1, zero 1; then result 0x0001, carry 0.
REQ-034 MUL src=0x0045, dst=0x0123 -> result 0x4E6F exactly 16 cycles after start; start pulse at cycle 5 is ignored; flags unchanged.
REQ-035 CMP src=5, dst=3 -> result 0, low 1, negative 1, zero 0; CMP src=dst=0x1234 -> zero 1, low 0; opcode 0x70 -> illegal 1, result 0.
REQ-036 Reset during MUL cycle 8 -> busy 0 immediately, no done pulse, result 0; next ADD 2+3 -> result 5 in 1 cycle.
